// File: rtl/arm_pkg.sv
// arm_pkg: shared ALU opcodes, shift-type codes and status-flag bit positions
package arm_pkg;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/val2_gen.sv
// val2_gen: second ALU operand from the address offset, rotated immediate or shifted register
module val2_gen
    import arm_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);
    logic [63:0] imm_rot, rm_rot;
    logic [4:0]  amt;
    logic [31:0] sh;

    always_comb begin
        amt     = shift_operand[11:7];
        // rotations take the low word of a doubled value shifted right
        imm_rot = {2{24'b0, shift_operand[7:0]}} >> {shift_operand[11:8], 1'b0};
        rm_rot  = {val_rm, val_rm} >> amt;
        case (shift_e'(shift_operand[6:5]))
            SH_LSL:  sh = val_rm << amt;
            SH_LSR:  sh = val_rm >> amt;
            SH_ASR:  sh = $signed(val_rm) >>> amt;
            default: sh = rm_rot[31:0];
        endcase
        val2 = mem_en ? {20'b0, shift_operand} : imm ? imm_rot[31:0] : sh;
    end
endmodule

// File: rtl/exe_pipe_unit.sv
// exe_pipe_unit: execute stage (ALU, flags, branch target), EXE/MEM register and RAW hazard detector
module exe_pipe_unit
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_CMD,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  SR,
    input  logic [3:0]  Dest_in,
    input  logic        Two_src,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    output logic [31:0] ALU_result,
    output logic [31:0] Br_addr,
    output logic [3:0]  status,
    output logic        WB_en,
    output logic        MEM_R_EN,
    output logic        MEM_W_EN,
    output logic [31:0] ALU_result_q,
    output logic [31:0] ST_val,
    output logic [3:0]  Dest,
    output logic        hazard_detected
);
    logic [31:0] val2, b;
    logic [32:0] sum;
    logic        cin, sub, arith;
    logic        wb_en_d, wb_en_q, mem_r_en_d, mem_r_en_q, mem_w_en_d, mem_w_en_q;
    logic [31:0] alu_res_d, alu_res_q, st_val_d, st_val_q;
    logic [3:0]  dest_d, dest_q;

    val2_gen u_val2 (
        .mem_en       (MEM_R_EN_in | MEM_W_EN_in),
        .imm          (imm),
        .shift_operand(Shift_operand),
        .val_rm       (Val_Rm),
        .val2         (val2)
    );

    // subtraction is Rn + ~Val2 + cin, so carry-out is the ARM no-borrow flag
    always_comb begin
        sub   = (EXE_CMD == CMD_SUB) || (EXE_CMD == CMD_SBC);
        arith = (EXE_CMD >= CMD_ADD) && (EXE_CMD <= CMD_SBC);
        b     = sub ? ~val2 : val2;
        cin   = (EXE_CMD == CMD_SUB) ? 1'b1 :
                ((EXE_CMD == CMD_ADC) || (EXE_CMD == CMD_SBC)) ? SR[FLAG_C] : 1'b0;
        sum   = {1'b0, Val_Rn} + {1'b0, b} + {32'b0, cin};
        case (EXE_CMD)
            CMD_MOV: ALU_result = val2;
            CMD_MVN: ALU_result = ~val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: ALU_result = sum[31:0];
            CMD_AND: ALU_result = Val_Rn & val2;
            CMD_ORR: ALU_result = Val_Rn | val2;
            CMD_EOR: ALU_result = Val_Rn ^ val2;
            default: ALU_result = 32'b0;
        endcase
        status[FLAG_N] = ALU_result[31];
        status[FLAG_Z] = ALU_result == 32'b0;
        status[FLAG_C] = arith ? sum[32] : SR[FLAG_C];
        status[FLAG_V] = arith ? (Val_Rn[31] == b[31]) && (sum[31] != Val_Rn[31]) : SR[FLAG_V];
        Br_addr = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    end

    always_comb begin
        wb_en_d    = WB_EN_in;
        mem_r_en_d = MEM_R_EN_in;
        mem_w_en_d = MEM_W_EN_in;
        alu_res_d  = ALU_result;
        st_val_d   = Val_Rm;
        dest_d     = Dest_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= 32'b0;
            st_val_q   <= 32'b0;
            dest_q     <= 4'b0;
        end else begin
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
        end
    end

    assign WB_en        = wb_en_q;
    assign MEM_R_EN     = mem_r_en_q;
    assign MEM_W_EN     = mem_w_en_q;
    assign ALU_result_q = alu_res_q;
    assign ST_val       = st_val_q;
    assign Dest         = dest_q;

    // MEM-stage terms use the registered destination, so they vanish during reset
    assign hazard_detected = (WB_EN_in && src1 == Dest_in) || (wb_en_q && src1 == dest_q) ||
                             (Two_src && ((WB_EN_in && src2 == Dest_in) || (wb_en_q && src2 == dest_q)));
endmodule

// File: tb/tb_exe_pipe_unit.sv
// tb_exe_pipe_unit: directed and random checks of exe_pipe_unit against an arithmetic reference model
module tb_exe_pipe_unit;
    logic        clk = 0, rst = 0;
    logic [3:0]  EXE_CMD = 0, SR = 0, Dest_in = 0, src1 = 0, src2 = 0;
    logic        WB_EN_in = 0, MEM_R_EN_in = 0, MEM_W_EN_in = 0, imm = 0, Two_src = 0;
    logic [31:0] PC = 0, Val_Rn = 0, Val_Rm = 0;
    logic [11:0] Shift_operand = 0;
    logic [23:0] Signed_imm_24 = 0;
    logic [31:0] ALU_result, Br_addr, ALU_result_q, ST_val;
    logic [3:0]  status, Dest;
    logic        WB_en, MEM_R_EN, MEM_W_EN, hazard_detected;

    int total = 0, bad = 0;
    logic        m_wb, m_mr, m_mw;
    logic [31:0] m_alu, m_st;
    logic [3:0]  m_dest;

    exe_pipe_unit dut (
        .clk(clk), .rst(rst), .EXE_CMD(EXE_CMD), .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in),
        .MEM_W_EN_in(MEM_W_EN_in), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .SR(SR), .Dest_in(Dest_in),
        .Two_src(Two_src), .src1(src1), .src2(src2), .ALU_result(ALU_result), .Br_addr(Br_addr),
        .status(status), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_result_q(ALU_result_q), .ST_val(ST_val), .Dest(Dest), .hazard_detected(hazard_detected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // right rotation / shifts expressed as division and multiplication by powers of two
    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        longint p = longint'(1) << n;
        longint u = longint'(x);
        return 32'((u / p) + (u % p) * ((longint'(1) << 32) / p));
    endfunction

    function automatic logic [31:0] m_val2(input logic mem, input logic im, input logic [11:0] so,
                                           input logic [31:0] rm);
        int n = int'(so[11:7]);
        longint p = longint'(1) << n;
        longint s = longint'($signed(rm));
        if (mem) return {20'b0, so};
        if (im) return m_ror({24'b0, so[7:0]}, 2 * int'(so[11:8]));
        case (so[6:5])
            2'd0: return 32'(longint'(rm) * p);
            2'd1: return 32'(longint'(rm) / p);
            2'd2: return 32'(s >= 0 ? s / p : -((-s + p - 1) / p));
            default: return m_ror(rm, n);
        endcase
    endfunction

    function automatic void m_exec(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                   input logic [3:0] sr, output logic [31:0] r, output logic [3:0] f);
        longint un = 0, sg = 0;
        longint ci = sr[1] ? 1 : 0;
        logic c = sr[1], v = sr[0];
        r = 0;
        case (cmd)
            4'd1: r = v2;
            4'd9: r = ~v2;
            4'd6: r = rn & v2;
            4'd7: r = rn | v2;
            4'd8: r = rn ^ v2;
            4'd2, 4'd3: begin
                un = longint'(rn) + longint'(v2) + (cmd == 4'd3 ? ci : 0);
                sg = longint'($signed(rn)) + longint'($signed(v2)) + (cmd == 4'd3 ? ci : 0);
                c  = un >= (longint'(1) << 32);
            end
            4'd4, 4'd5: begin
                un = longint'(rn) - longint'(v2) - (cmd == 4'd5 ? 1 - ci : 0);
                sg = longint'($signed(rn)) - longint'($signed(v2)) - (cmd == 4'd5 ? 1 - ci : 0);
                c  = un >= 0;
            end
            default: r = 0;
        endcase
        if (cmd >= 4'd2 && cmd <= 4'd5) begin
            r = 32'(un);
            v = sg > 64'sd2147483647 || sg < -64'sd2147483648;
        end
        f = {r[31], r == 0, c, v};
    endfunction

    task automatic chk_comb(input string tag);
        logic [31:0] r, v2;
        logic [3:0]  f;
        logic        hz;
        v2 = m_val2(MEM_R_EN_in | MEM_W_EN_in, imm, Shift_operand, Val_Rm);
        m_exec(EXE_CMD, Val_Rn, v2, SR, r, f);
        hz = (WB_EN_in && src1 == Dest_in) || (m_wb && src1 == m_dest) ||
             (Two_src && WB_EN_in && src2 == Dest_in) || (Two_src && m_wb && src2 == m_dest);
        chk({tag, "_alu"}, ALU_result, r);
        chk({tag, "_status"}, {28'b0, status}, {28'b0, f});
        chk({tag, "_br"}, Br_addr, PC + 32'($signed(Signed_imm_24) * 4));
        chk({tag, "_hazard"}, {31'b0, hazard_detected}, {31'b0, hz});
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_wb"}, {31'b0, WB_en}, {31'b0, m_wb});
        chk({tag, "_mr"}, {31'b0, MEM_R_EN}, {31'b0, m_mr});
        chk({tag, "_mw"}, {31'b0, MEM_W_EN}, {31'b0, m_mw});
        chk({tag, "_aluq"}, ALU_result_q, m_alu);
        chk({tag, "_st"}, ST_val, m_st);
        chk({tag, "_dest"}, {28'b0, Dest}, {28'b0, m_dest});
    endtask

    task automatic capture_model();
        logic [3:0] f;
        m_wb = WB_EN_in; m_mr = MEM_R_EN_in; m_mw = MEM_W_EN_in;
        m_exec(EXE_CMD, Val_Rn, m_val2(MEM_R_EN_in | MEM_W_EN_in, imm, Shift_operand, Val_Rm), SR, m_alu, f);
        m_st = Val_Rm; m_dest = Dest_in;
    endtask

    task automatic rand_inputs();
        EXE_CMD = 4'($urandom); SR = 4'($urandom);
        WB_EN_in = 1'($urandom); MEM_R_EN_in = ($urandom_range(0, 3) == 0);
        MEM_W_EN_in = ($urandom_range(0, 3) == 0); imm = 1'($urandom);
        PC = $urandom; Val_Rn = $urandom; Val_Rm = $urandom;
        Shift_operand = 12'($urandom); Signed_imm_24 = 24'($urandom);
        Dest_in = 4'($urandom_range(0, 3)); src1 = 4'($urandom_range(0, 3));
        src2 = 4'($urandom_range(0, 3)); Two_src = 1'($urandom);
        if ($urandom_range(0, 7) == 0) Val_Rn = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) Val_Rm = Val_Rn;
    endtask

    initial begin
        m_wb = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_st = 0; m_dest = 0;
        #2;
        chk_regs("reset");
        // directed cases, evaluated while reset holds the MEM-stage terms at zero
        EXE_CMD = 4'b0010; Val_Rn = 5; Val_Rm = 3; #1;
        chk("add_res", ALU_result, 32'd8); chk("add_st", {28'b0, status}, 32'b0000);
        EXE_CMD = 4'b0100; Val_Rm = 5; #1;
        chk("sub_res", ALU_result, 32'd0); chk("sub_st", {28'b0, status}, 32'b0110);
        Val_Rn = 32'h8000_0000; Val_Rm = 1; #1;
        chk("subv_res", ALU_result, 32'h7FFF_FFFF); chk("subv_st", {28'b0, status}, 32'b0011);
        EXE_CMD = 4'b0001; imm = 1; Shift_operand = 12'h2FF; #1;
        chk("movi_res", ALU_result, 32'hF000_000F); chk("movi_n", {31'b0, status[3]}, 32'd1);
        imm = 0; Val_Rm = 32'h8000_0000; Shift_operand = 12'h240; #1;
        chk("asr_res", ALU_result, 32'hF800_0000);
        EXE_CMD = 4'b0010; MEM_R_EN_in = 1; imm = 1; Shift_operand = 12'h2FF; Val_Rn = 32'h100; #1;
        chk("addr_res", ALU_result, 32'h3FF);
        PC = 32'h100; Signed_imm_24 = 24'hFFFFFE; #1;
        chk("br", Br_addr, 32'hF8);
        MEM_R_EN_in = 0; imm = 0;
        Dest_in = 3; WB_EN_in = 1; src1 = 3; src2 = 0; Two_src = 0; #1;
        chk("hz_src1", {31'b0, hazard_detected}, 32'd1);
        src1 = 2; src2 = 3; #1;
        chk("hz_two0", {31'b0, hazard_detected}, 32'd0);
        Two_src = 1; #1;
        chk("hz_two1", {31'b0, hazard_detected}, 32'd1);
        WB_EN_in = 0; src1 = 3; #1;
        chk("hz_nowb", {31'b0, hazard_detected}, 32'd0);
        src1 = 4'hF; Dest_in = 4'hF; WB_EN_in = 1; Two_src = 0; #1;
        chk("hz_r15", {31'b0, hazard_detected}, 32'd1);
        chk_regs("reset_hold");
        // release and capture one ADD 5+3 into Dest 3
        @(negedge clk);
        rst = 1;
        EXE_CMD = 4'b0010; Val_Rn = 5; Val_Rm = 3; Shift_operand = 0; Dest_in = 3; WB_EN_in = 1;
        src1 = 0; src2 = 0;
        @(posedge clk); #1;
        chk("reg_dest", {28'b0, Dest}, 32'd3); chk("reg_alu", ALU_result_q, 32'd8);
        capture_model();
        chk_regs("reg_first");
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_inputs();
            #1;
            chk_comb("rnd");
            capture_model();
            @(posedge clk); #1;
            chk_regs("rnd_q");
            if (i == 200) begin
                // asynchronous reset mid-operation, away from any clock edge
                #2; rst = 0; #1;
                m_wb = 0; m_mr = 0; m_mw = 0; m_alu = 0; m_st = 0; m_dest = 0;
                chk_regs("async_rst");
                #1; chk_comb("rst_comb");
                @(negedge clk); rst = 1;
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_pipe_unit.md
# exe_pipe_unit

Execute-stage block of the 5-stage ARM-subset pipeline: combinational ALU with second-operand generator, branch-target adder and status-flag generation, followed by the EXE/MEM pipeline register. Also hosts the combinational RAW hazard detector that freezes IF/ID when a decoded source register matches a pending write in EXE or MEM. Sits between the ID/EXE register and the memory stage; `status` feeds the status register, and `hazard_detected` feeds the IF/ID freeze.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- EXE_CMD  in  4  ALU opcode
- WB_EN_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits of the instruction in EXE
- PC  in  32  PC+4 of the instruction in EXE
- Val_Rn, Val_Rm  in  32  register operands
- imm  in  1  immediate-operand flag
- Shift_operand  in  12  operand-2 field
- Signed_imm_24  in  24  branch offset (words)
- SR  in  4  current flags {N,Z,C,V}
- Dest_in  in  4  destination register of the instruction in EXE
- Two_src  in  1  ID instruction reads src2
- src1, src2  in  4  ID source registers
- ALU_result  out  32  combinational ALU output
- Br_addr  out  32  combinational branch target
- status  out  4  combinational {N,Z,C,V}
- WB_en, MEM_R_EN, MEM_W_EN  out  1  registered controls
- ALU_result_q  out  32  registered ALU result
- ST_val  out  32  registered store data (Val_Rm)
- Dest  out  4  registered destination
- hazard_detected  out  1  combinational stall request

## Operation
- Val2 priority:
  - MEM_R_EN_in|MEM_W_EN_in → zero-extended Shift_operand[11:0].
  - Else imm → {24'b0,Shift_operand[7:0]} rotated right by 2·Shift_operand[11:8].
  - Else Val_Rm shifted by Shift_operand[11:7] with type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 = no shift.
- EXE_CMD:
  - 0001 MOV=Val2; 1001 MVN=~Val2
  - 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C
  - 0100 SUB=Rn−Val2; 0101 SBC=Rn−Val2−!C
  - 0110 AND; 0111 ORR; 1000 EOR
  - Others → result 0.
  - CMP/TST/LDR/STR are encoded by ID as SUB/AND/ADD/ADD.
- Flags:
  - N=result[31]; Z=(result==0).
  - Arithmetic ops: C = 33-bit carry out (subtract: C=1 means no borrow, ARM convention); V = signed overflow.
  - Logic/move/unused ops: C and V pass through from SR.
- Br_addr = PC + (sign-extend(Signed_imm_24) << 2), 32-bit wraparound.
- Register: each clock it captures WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result, Val_Rm, Dest_in. No enable, no flush.
- hazard_detected = (WB_EN_in & src1==Dest_in) | (WB_en & src1==Dest) | (Two_src & WB_EN_in & src2==Dest_in) | (Two_src & WB_en & src2==Dest).
  - The EXE-stage comparison uses the block inputs; the MEM-stage comparison uses this block's registered outputs.
  - All 16 register numbers are compared, R15 included.

## Timing
- ALU_result, Br_addr, status and hazard_detected are purely combinational, with zero cycle latency.
- Registered outputs update on the rising edge, one-cycle latency.
- rst low asynchronously clears every registered output to 0. While rst is low, the MEM-side hazard term is therefore 0.
- Releasing rst mid-operation resumes capture on the next rising edge.

## Structure
- Shared package `arm_pkg`: EXE_CMD localparams, shift-type codes, flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-modules:
  - `val2_gen` (operand-2 generator).
  - ALU, EXE/MEM register and hazard detector as always blocks in the top.

## Test plan
- ADD: Rn=5, Rm=3, imm=0, Shift_operand=0 → ALU_result 8, status 0000; SUB 5−5 → 0, status 0110.
- SUB: Rn=0x80000000, Val2=1 → 0x7FFFFFFF, status 0011 (V=1, C=1).
- MOV: imm=1, Shift_operand=0x2FF → 0xF000000F, N=1; MOV register, Rm=0x80000000, Shift_operand=0x240 (ASR 4) → 0xF8000000.
- Address generation: MEM_R_EN_in=1, imm=1, Shift_operand=0x2FF, Rn=0x100, ADD → 0x3FF (zero-extend, not rotated).
- Branch: PC=0x100, Signed_imm_24=0xFFFFFE → Br_addr 0xF8.
- Register: rst=0 → all registered outputs 0. Release, drive Dest_in=3, WB_EN_in=1, ALU_result 8 → after next edge Dest=3, ALU_result_q=8.
- Hazard with Dest_in=3, WB_EN_in=1:
  - src1=3 → hazard_detected 1.
  - src1=2, src2=3, Two_src=0 → 0; Two_src=1 → 1.
  - WB_EN_in=0 with matching src → 0.
